dmem_responder: RTL and testbench



---
 rtl/riscv_mem_pkg.sv | 29 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states and
// access-size decode.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SECOND,
    RESP
  } state_e;

  // Access size in bytes; 0 marks an unsupported funct3 for the given direction.
  function automatic logic [2:0] size_of(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B:    return 3'd1;
      F3_H:    return 3'd2;
      F3_W:    return 3'd4;
      F3_BU:   return we ? 3'd0 : 3'd1;
      F3_HU:   return we ? 3'd0 : 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DADDR = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [DADDR+1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a possibly word-crossing access: store enables/data over a
// two-word window and extracted, extended load data.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [2:0]  size_o,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  mask;
  logic [31:0] wmask;
  logic [31:0] window;

  always_comb begin
    size_o = size_of(we_i, funct3_i);
    mask   = 4'b0000;
    wmask  = 32'h0;
    case (size_o)
      3'd1:    begin mask = 4'b0001; wmask = 32'h0000_00ff; end
      3'd2:    begin mask = 4'b0011; wmask = 32'h0000_ffff; end
      3'd4:    begin mask = 4'b1111; wmask = 32'hffff_ffff; end
      default: begin mask = 4'b0000; wmask = 32'h0; end
    endcase

    be_o    = {4'b0000, mask} << offset_i;
    wdata_o = {32'h0, wdata_i & wmask} << {offset_i, 3'b000};

    // Low 32 bits of the shifted window always hold the addressed bytes.
    window  = 32'({hi_i, lo_i} >> {offset_i, 3'b000});
    case (funct3_i)
      F3_B:    rdata_o = {{24{window[7]}}, window[7:0]};
      F3_H:    rdata_o = {{16{window[15]}}, window[15:0]};
      F3_W:    rdata_o = window;
      F3_BU:   rdata_o = {24'h0, window[7:0]};
      F3_HU:   rdata_o = {16'h0, window[15:0]};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the word array and serves byte/half/word loads and stores,
// splitting word-crossing accesses into two word accesses.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DADDR = 5
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned Depth = 2 ** DADDR;

  logic [WIDTH-1:0] mem_q [Depth];

  state_e           state_q, state_d;
  logic             we_q, err_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [DADDR-1:0] w_q;
  logic [31:0]      wdata_q, lo_q, hi_q;

  logic             idle, accept, err_now, split_now;
  logic [DADDR-1:0] w_now, w_next;
  logic             ln_we;
  logic [2:0]       ln_f3, ln_size;
  logic [1:0]       ln_off;
  logic [31:0]      ln_wdata, ln_rdata;
  logic [7:0]       ln_be;
  logic [63:0]      ln_wd;

  logic             mem_we;
  logic [DADDR-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wd;

  assign idle   = (state_q == IDLE);
  assign accept = idle && bus.req_valid && !reset;
  assign w_now  = bus.req_addr[DADDR+1:2];
  assign w_next = w_q + {{(DADDR-1){1'b0}}, 1'b1};

  // Live request fields steer the lanes in IDLE, the latched ones afterwards.
  assign ln_we    = idle ? bus.req_we               : we_q;
  assign ln_f3    = idle ? bus.req_funct3           : f3_q;
  assign ln_off   = idle ? bus.req_addr[1:0]        : off_q;
  assign ln_wdata = idle ? bus.req_wdata            : wdata_q;

  dmem_lane_align u_lane_align (
    .funct3_i (ln_f3),
    .we_i     (ln_we),
    .offset_i (ln_off),
    .wdata_i  (ln_wdata),
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .size_o   (ln_size),
    .be_o     (ln_be),
    .wdata_o  (ln_wd),
    .rdata_o  (ln_rdata)
  );

  assign err_now   = (ln_size == 3'd0);
  assign split_now = !err_now && (({2'b00, ln_off} + {1'b0, ln_size}) > 4'd4);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = split_now ? SECOND : RESP;
      SECOND:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = w_now;
    mem_be  = 4'b0000;
    mem_wd  = 32'h0;
    if (accept && bus.req_we && !err_now) begin
      mem_we  = 1'b1;
      mem_idx = w_now;
      mem_be  = ln_be[3:0];
      mem_wd  = ln_wd[31:0];
    end else if ((state_q == SECOND) && we_q && !reset) begin
      mem_we  = 1'b1;
      mem_idx = w_next;
      mem_be  = ln_be[7:4];
      mem_wd  = ln_wd[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      w_q     <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= err_now;
        f3_q    <= bus.req_funct3;
        off_q   <= bus.req_addr[1:0];
        w_q     <= w_now;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Storage and read-data registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
    if (accept) lo_q <= mem_q[w_now];
    if (state_q == SECOND && !reset) hi_q <= mem_q[w_next];
  end

  assign bus.req_ready = idle && !reset;
  assign bus.rsp_valid = (state_q == RESP) && !reset;
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? ln_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder plus hand-written reset corner cases.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.WIDTH(32), .DADDR(5)) bus ();

  dmem_responder #(.WIDTH(32), .DADDR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input logic exp_err, input int exp_lat);
    vecs.push_back('{we, f3, addr, wd, exp_rd, exp_err, exp_lat});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+#1. Latency counts the accept cycle as cycle 1.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic rdy_in_rsp, output logic pulse_after);
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    lat = 2;
    while (bus.rsp_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    rd         = bus.rsp_rdata;
    er         = bus.rsp_err;
    rdy_in_rsp = bus.req_ready;
    @(posedge clk); #1;
    pulse_after = bus.rsp_valid;
  endtask

  task automatic run(input string name, input logic we, input logic [2:0] f3,
                     input logic [6:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [31:0] rd;
    logic        er, rdy, pa;
    int          lat;
    xact(we, f3, addr, wd, rd, er, lat, rdy, pa);
    chk(name, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er, rdy, pa;
    int          lat;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;

    add(1'b1, F3_W,  7'h08, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    add(1'b0, F3_W,  7'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    add(1'b0, F3_B,  7'h09, 32'h0,        32'hFFFFFFBE, 1'b0, 2);
    add(1'b0, F3_BU, 7'h09, 32'h0,        32'h000000BE, 1'b0, 2);
    add(1'b1, F3_B,  7'h0A, 32'h00000012, 32'h0,        1'b0, 2);
    add(1'b0, F3_W,  7'h08, 32'h0,        32'hDE12BEEF, 1'b0, 2);
    add(1'b1, F3_W,  7'h10, 32'h44332211, 32'h0,        1'b0, 2);
    add(1'b1, F3_W,  7'h14, 32'h88776655, 32'h0,        1'b0, 2);
    add(1'b0, F3_W,  7'h13, 32'h0,        32'h77665544, 1'b0, 3);
    add(1'b0, F3_H,  7'h13, 32'h0,        32'h00005544, 1'b0, 3);
    add(1'b0, F3_H,  7'h16, 32'h0,        32'hFFFF8877, 1'b0, 2);
    add(1'b0, F3_HU, 7'h16, 32'h0,        32'h00008877, 1'b0, 2);
    add(1'b0, F3_B,  7'h13, 32'h0,        32'h00000044, 1'b0, 2);
    add(1'b1, F3_W,  7'h7C, 32'h55667788, 32'h0,        1'b0, 2);
    add(1'b1, F3_W,  7'h00, 32'h99AABBCC, 32'h0,        1'b0, 2);
    add(1'b1, F3_W,  7'h7E, 32'hA1B2C3D4, 32'h0,        1'b0, 3);
    add(1'b0, F3_W,  7'h7C, 32'h0,        32'hC3D47788, 1'b0, 2);
    add(1'b0, F3_W,  7'h00, 32'h0,        32'h99AAA1B2, 1'b0, 2);
    add(1'b0, F3_W,  7'h7E, 32'h0,        32'hA1B2C3D4, 1'b0, 3);
    add(1'b0, 3'b011, 7'h00, 32'h0,       32'h0,        1'b1, 2);
    add(1'b0, 3'b110, 7'h01, 32'h0,       32'h0,        1'b1, 2);
    add(1'b1, 3'b100, 7'h00, 32'hFFFFFFFF, 32'h0,       1'b1, 2);
    add(1'b1, 3'b011, 7'h03, 32'hFFFFFFFF, 32'h0,       1'b1, 2);
    add(1'b0, F3_W,  7'h00, 32'h0,        32'h99AAA1B2, 1'b0, 2);
    add(1'b0, F3_W,  7'h04, 32'h0,        32'h0,        1'b0, 2);
    add(1'b1, F3_W,  7'h20, 32'h0,        32'h0,        1'b0, 2);
    add(1'b1, F3_H,  7'h20, 32'h1234CAFE, 32'h0,        1'b0, 2);
    add(1'b0, F3_W,  7'h20, 32'h0,        32'h0000CAFE, 1'b0, 2);

    // Word 1 is read back as zero above, so it must be written first.
    vecs.insert(22, '{1'b1, F3_W, 7'h04, 32'h0, 32'h0, 1'b0, 2});

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat, rdy, pa);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_ready_in_rsp", i), {31'h0, rdy}, 32'h0);
      chk($sformatf("v%0d_pulse_width", i), {31'h0, pa}, 32'h0);
    end

    // Reset while a split store sits in SECOND: first half kept, second half dropped.
    run("pre_w0", 1'b1, F3_W, 7'h00, 32'h11223344, 32'h0);
    run("pre_w1", 1'b1, F3_W, 7'h04, 32'h55667788, 32'h0);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 7'h03;
    bus.req_wdata  = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("second_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("second_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("midreset_ready_back", {31'h0, bus.req_ready}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midreset_no_rsp_%0d", c), {31'h0, bus.rsp_valid}, 32'h0);
    end
    run("midreset_w0", 1'b0, F3_W, 7'h00, 32'h0, 32'hDD223344);
    run("midreset_w1", 1'b0, F3_W, 7'h04, 32'h0, 32'h55667788);

    // Reset wins over a simultaneous request.
    reset          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 7'h20;
    bus.req_wdata  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("prio_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("prio_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    run("prio_mem_unchanged", 1'b0, F3_W, 7'h20, 32'h0, 32'h0000CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
